// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : System reset generator for the clk_sys domain. Waits for a
//               synchronised MMCM lock, stretches reset for RST_LEN cycles,
//               then releases N_CH active-high reset channels in ascending
//               order, STAGE_GAP cycles apart. Lock loss or a software
//               request re-arms the sequence.
// Optional    : RESET_SEQ_EVT_CNT_EN - when defined, adds the saturating
//               abort event counter and the evt_cnt output port.
// Ports       : clk_sys     in   system clock
//               rst_sys     in   synchronous active-high reset
//               locked      in   MMCM lock (asynchronous to clk_sys)
//               sw_rst_req  in   software reset request (level, clk_sys)
//               rst_out     out  per-channel reset, active-high, registered
//               all_done    out  every channel released, registered
//               evt_cnt     out  abort event count (optional feature only)
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int N_CH             = 4,
    parameter int RST_LEN          = 1000,
    parameter int STAGE_GAP        = 16,
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int EVT_CNT_W        = 8
) (
    input  logic            clk_sys,
    input  logic            rst_sys,
    input  logic            locked,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            all_done
`ifdef RESET_SEQ_EVT_CNT_EN
    ,
    output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_max = (RST_LEN > STAGE_GAP) ? RST_LEN : STAGE_GAP;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_ch_w    = $clog2(N_CH + 1);

    localparam logic [c_cnt_w-1:0] c_stretch_last = c_cnt_w'(RST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(STAGE_GAP - 1);
    localparam logic [c_ch_w-1:0]  c_ch_last      = c_ch_w'(N_CH - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (N_CH < 1) begin : g_chk_n_ch
        $error("reset_sequencer: N_CH must be >= 1");
    end
    if (RST_LEN < 1) begin : g_chk_rst_len
        $error("reset_sequencer: RST_LEN must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_stage_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (LOCK_SYNC_STAGES < 2) begin : g_chk_sync
        $error("reset_sequencer: LOCK_SYNC_STAGES must be >= 2");
    end
    if (EVT_CNT_W < 1) begin : g_chk_evt_w
        $error("reset_sequencer: EVT_CNT_W must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Lock synchroniser: locked is asynchronous, only the last stage is used.
    // ------------------------------------------------------------------------
    logic [LOCK_SYNC_STAGES-1:0] r_lock_sync;
    logic                        w_locked_s;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[LOCK_SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_lock_sync[LOCK_SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,      w_cnt_nxt;
    logic [c_ch_w-1:0]  r_ch,       w_ch_nxt;
    logic [N_CH-1:0]    r_rst_out,  w_rst_out_nxt;
    logic               r_all_done, w_all_done_nxt;
    logic [c_ch_w-1:0]  w_ch_inc;
    logic               w_abort;

    // Abort condition; only acted on outside WAIT_LOCK.
    assign w_abort  = !w_locked_s || sw_rst_req;
    assign w_ch_inc = r_ch + c_ch_w'(1);

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_rst_out  <= '1;
            r_all_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ch       <= w_ch_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_all_done <= w_all_done_nxt;
        end
    end

    // Releases are a left shift of the reset vector: a zero enters at bit 0
    // and walks upward, so channel i can never drop before channel i-1.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ch_nxt       = r_ch;
        w_rst_out_nxt  = r_rst_out;
        w_all_done_nxt = r_all_done;

        case (r_state)
            ST_WAIT_LOCK: begin
                w_rst_out_nxt  = '1;
                w_all_done_nxt = 1'b0;
                w_cnt_nxt      = '0;
                w_ch_nxt       = '0;
                if (w_locked_s && !sw_rst_req) begin
                    w_state_nxt = ST_STRETCH;
                end
            end

            ST_STRETCH: begin
                if (w_abort) begin
                    w_state_nxt    = ST_WAIT_LOCK;
                    w_rst_out_nxt  = '1;
                    w_all_done_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_ch_nxt       = '0;
                end else if (r_cnt == c_stretch_last) begin
                    w_cnt_nxt     = '0;
                    w_ch_nxt      = '0;
                    w_rst_out_nxt = r_rst_out << 1;
                    if (N_CH == 1) begin
                        // Single channel: its release completes the sequence.
                        w_state_nxt    = ST_RUN;
                        w_all_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            ST_RELEASE: begin
                if (w_abort) begin
                    w_state_nxt    = ST_WAIT_LOCK;
                    w_rst_out_nxt  = '1;
                    w_all_done_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_ch_nxt       = '0;
                end else if (r_cnt == c_gap_last) begin
                    w_cnt_nxt     = '0;
                    w_ch_nxt      = w_ch_inc;
                    w_rst_out_nxt = r_rst_out << 1;
                    if (w_ch_inc == c_ch_last) begin
                        w_state_nxt    = ST_RUN;
                        w_all_done_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt    = ST_WAIT_LOCK;
                    w_rst_out_nxt  = '1;
                    w_all_done_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_ch_nxt       = '0;
                end
            end

            default: begin
                w_state_nxt    = ST_WAIT_LOCK;
                w_rst_out_nxt  = '1;
                w_all_done_nxt = 1'b0;
                w_cnt_nxt      = '0;
                w_ch_nxt       = '0;
            end
        endcase
    end

    assign rst_out  = r_rst_out;
    assign all_done = r_all_done;

    // ------------------------------------------------------------------------
    // Optional abort event counter (saturating, cleared only by rst_sys).
    // Lock loss and software request in the same cycle are one event.
    // ------------------------------------------------------------------------
`ifdef RESET_SEQ_EVT_CNT_EN
    logic [EVT_CNT_W-1:0] r_evt_cnt;
    logic                 w_evt;

    assign w_evt = (r_state != ST_WAIT_LOCK) && w_abort;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_evt_cnt <= '0;
        end else if (w_evt && (r_evt_cnt != '1)) begin
            r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
        end
    end

    assign evt_cnt = r_evt_cnt;
`endif

endmodule
`default_nettype wire
